// File: rtl/distribute_switch_seq.sv
`default_nettype none
// ============================================================================
// Module      : distribute_switch_seq
// Description : Sequential 1-to-2 distribute switch. Each accepted upstream
//               word is steered to the low branch, the high branch, both
//               (atomic multicast) or dropped, under control of i_cmd. Each
//               branch owns a small FIFO so a stalled branch never loses data.
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   i_valid      upstream word valid
//   i_data_bus   upstream word (DATA_WIDTH bits, opaque)
//   i_cmd        destination: 00 drop, 01 low, 10 high, 11 both
//   i_en         switch enable (gates acceptance only)
//   o_ready      switch can accept the current word
//   o_valid      per-branch valid, [0] low, [1] high
//   o_data_bus   {high word, low word}; a slice reads 0 when its valid is 0
//   i_ready      per-branch downstream ready, [0] low, [1] high
//
// Revision    : 1.0 - initial release
// ============================================================================
module distribute_switch_seq #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 2   // power of 2, at least 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_valid,
  input  logic [DATA_WIDTH-1:0]   i_data_bus,
  input  logic [1:0]              i_cmd,
  input  logic                    i_en,
  output logic                    o_ready,
  output logic [1:0]              o_valid,
  output logic [2*DATA_WIDTH-1:0] o_data_bus,
  input  logic [1:0]              i_ready
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [PTR_W-1:0] c_ptr_one  = PTR_W'(1);
  localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);
  localparam logic [CNT_W-1:0] c_cnt_full = CNT_W'(FIFO_DEPTH);

  logic [1:0] w_full;
  logic [1:0] w_push;
  logic [1:0] w_pop;
  logic       w_accept;

  // Readiness only looks at branches the current word targets, and uses the
  // registered counts: a full branch refuses even if it pops this cycle, so
  // o_ready never depends on i_ready.
  assign o_ready  = i_en
                  & ~(i_cmd[0] & w_full[0])
                  & ~(i_cmd[1] & w_full[1]);
  assign w_accept = i_valid & o_ready;

  genvar b;
  generate
    for (b = 0; b < 2; b++) begin : g_branch
      logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
      logic [PTR_W-1:0]      wr_ptr_q;
      logic [PTR_W-1:0]      wr_ptr_d;
      logic [PTR_W-1:0]      rd_ptr_q;
      logic [PTR_W-1:0]      rd_ptr_d;
      logic [CNT_W-1:0]      count_q;
      logic [CNT_W-1:0]      count_d;

      assign w_full[b]  = (count_q == c_cnt_full);
      assign o_valid[b] = (count_q != '0);
      assign w_pop[b]   = o_valid[b] & i_ready[b];
      // Shared w_accept makes the multicast push atomic across branches.
      assign w_push[b]  = w_accept & i_cmd[b];

      always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        // Pointers are PTR_W bits wide, so they wrap modulo FIFO_DEPTH.
        if (w_push[b]) begin
          wr_ptr_d = wr_ptr_q + c_ptr_one;
        end
        if (w_pop[b]) begin
          rd_ptr_d = rd_ptr_q + c_ptr_one;
        end
        case ({w_push[b], w_pop[b]})
          2'b10:   count_d = count_q + c_cnt_one;
          2'b01:   count_d = count_q - c_cnt_one;
          default: count_d = count_q;
        endcase
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          wr_ptr_q <= '0;
          rd_ptr_q <= '0;
          count_q  <= '0;
        end else begin
          wr_ptr_q <= wr_ptr_d;
          rd_ptr_q <= rd_ptr_d;
          count_q  <= count_d;
        end
      end

      // Storage is never reset; stale entries are masked by count_q.
      always_ff @(posedge clk) begin
        if (w_push[b] && !rst) begin
          mem_q[wr_ptr_q] <= i_data_bus;
        end
      end

      assign o_data_bus[b*DATA_WIDTH +: DATA_WIDTH] =
        o_valid[b] ? mem_q[rd_ptr_q] : {DATA_WIDTH{1'b0}};
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_distribute_switch_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_distribute_switch_seq
// Description : Self-checking bench for distribute_switch_seq. A queue-based
//               reference model tracks the content of each branch and
//               predicts o_ready, o_valid and o_data_bus every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_distribute_switch_seq;

  localparam int DW    = 32;
  localparam int DEPTH = 2;

  logic          clk;
  logic          rst;
  logic          i_valid;
  logic [DW-1:0] i_data_bus;
  logic [1:0]    i_cmd;
  logic          i_en;
  logic          o_ready;
  logic [1:0]    o_valid;
  logic [2*DW-1:0] o_data_bus;
  logic [1:0]    i_ready;

  int n_tot = 0;
  int n_bad = 0;

  // Reference model: one queue of words per branch, in delivery order.
  logic [DW-1:0] mq0[$];
  logic [DW-1:0] mq1[$];

  distribute_switch_seq #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .i_valid    (i_valid),
    .i_data_bus (i_data_bus),
    .i_cmd      (i_cmd),
    .i_en       (i_en),
    .o_ready    (o_ready),
    .o_valid    (o_valid),
    .o_data_bus (o_data_bus),
    .i_ready    (i_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic m_ready();
    return i_en && !(i_cmd[0] && mq0.size() == DEPTH)
                && !(i_cmd[1] && mq1.size() == DEPTH);
  endfunction

  function automatic logic [1:0] m_valid();
    return {mq1.size() != 0, mq0.size() != 0};
  endfunction

  function automatic logic [2*DW-1:0] m_data();
    logic [DW-1:0] lo;
    logic [DW-1:0] hi;
    lo = (mq0.size() != 0) ? mq0[0] : '0;
    hi = (mq1.size() != 0) ? mq1[0] : '0;
    return {hi, lo};
  endfunction

  // Apply inputs just after an edge, then wait to mid-cycle for sampling.
  task automatic drive(input logic r, input logic v, input logic [DW-1:0] d,
                       input logic [1:0] c, input logic e, input logic [1:0] rd);
    rst = r; i_valid = v; i_data_bus = d; i_cmd = c; i_en = e; i_ready = rd;
    #4;
  endtask

  // Let the clock edge happen and update the model with what it implies.
  task automatic advance();
    logic acc;
    logic p0;
    logic p1;
    acc = i_valid && m_ready();
    p0  = (mq0.size() != 0) && i_ready[0];
    p1  = (mq1.size() != 0) && i_ready[1];
    @(posedge clk);
    if (rst) begin
      mq0.delete();
      mq1.delete();
    end else begin
      if (p0) void'(mq0.pop_front());
      if (p1) void'(mq1.pop_front());
      if (acc && i_cmd[0]) mq0.push_back(i_data_bus);
      if (acc && i_cmd[1]) mq1.push_back(i_data_bus);
    end
    #1;
  endtask

  task automatic test_reset();
    drive(1'b1, 1'b1, 32'h12345678, 2'b11, 1'b1, 2'b11);
    advance();
    for (int k = 0; k < 2; k++) begin
      drive(1'b1, 1'b1, 32'h12345678, 2'b11, 1'b1, 2'b11);
      n_tot++;
      if (o_valid !== 2'b00 || o_data_bus !== '0) begin
        n_bad++;
        $display("FAIL reset_hold cyc%0d: got vld=%b data=%h, want vld=00 data=0",
                 k, o_valid, o_data_bus);
      end
      advance();
    end
    drive(1'b0, 1'b0, '0, 2'b11, 1'b1, 2'b11);
    n_tot++;
    if (o_ready !== 1'b1 || o_valid !== 2'b00) begin
      n_bad++;
      $display("FAIL reset_release: got rdy=%b vld=%b, want rdy=1 vld=00", o_ready, o_valid);
    end
    advance();
  endtask

  task automatic test_unicast();
    drive(1'b0, 1'b1, 32'hAAAAAAAA, 2'b01, 1'b1, 2'b11);
    n_tot++;
    if (o_ready !== m_ready() || o_valid !== m_valid() || o_data_bus !== m_data()) begin
      n_bad++;
      $display("FAIL unicast_a: got rdy=%b vld=%b data=%h, want rdy=%b vld=%b data=%h",
               o_ready, o_valid, o_data_bus, m_ready(), m_valid(), m_data());
    end
    advance();
    drive(1'b0, 1'b1, 32'hBBBBBBBB, 2'b10, 1'b1, 2'b11);
    n_tot++;
    if (o_valid !== 2'b01 || o_data_bus !== {32'h0, 32'hAAAAAAAA}) begin
      n_bad++;
      $display("FAIL unicast_low: got vld=%b data=%h, want vld=01 data=00000000aaaaaaaa",
               o_valid, o_data_bus);
    end
    advance();
    drive(1'b0, 1'b0, '0, 2'b00, 1'b1, 2'b11);
    n_tot++;
    if (o_valid !== 2'b10 || o_data_bus !== {32'hBBBBBBBB, 32'h0}) begin
      n_bad++;
      $display("FAIL unicast_high: got vld=%b data=%h, want vld=10 data=bbbbbbbb00000000",
               o_valid, o_data_bus);
    end
    advance();
  endtask

  task automatic test_multicast_drop();
    drive(1'b0, 1'b1, 32'hCCCCCCCC, 2'b11, 1'b1, 2'b11);
    advance();
    drive(1'b0, 1'b1, 32'hDDDDDDDD, 2'b00, 1'b1, 2'b11);
    n_tot++;
    if (o_ready !== 1'b1 || o_valid !== 2'b11 || o_data_bus !== {2{32'hCCCCCCCC}}) begin
      n_bad++;
      $display("FAIL multicast: got rdy=%b vld=%b data=%h, want rdy=1 vld=11 data=cccccccccccccccc",
               o_ready, o_valid, o_data_bus);
    end
    advance();
    for (int k = 0; k < 2; k++) begin
      drive(1'b0, 1'b0, '0, 2'b00, 1'b1, 2'b11);
      n_tot++;
      if (o_valid !== 2'b00 || o_data_bus !== '0) begin
        n_bad++;
        $display("FAIL drop cyc%0d: got vld=%b data=%h, want vld=00 data=0",
                 k, o_valid, o_data_bus);
      end
      advance();
    end
  endtask

  task automatic test_backpressure();
    drive(1'b0, 1'b1, 32'd1, 2'b11, 1'b1, 2'b10);
    n_tot++;
    if (o_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL bp_w1_ready: got %b want 1", o_ready);
    end
    advance();
    drive(1'b0, 1'b1, 32'd2, 2'b11, 1'b1, 2'b10);
    n_tot++;
    if (o_ready !== 1'b1 || o_valid !== 2'b11 || o_data_bus[63:32] !== 32'd1) begin
      n_bad++;
      $display("FAIL bp_w2: got rdy=%b vld=%b high=%h, want rdy=1 vld=11 high=1",
               o_ready, o_valid, o_data_bus[63:32]);
    end
    advance();
    drive(1'b0, 1'b1, 32'd3, 2'b11, 1'b1, 2'b10);
    n_tot++;
    if (o_ready !== 1'b0 || o_data_bus[63:32] !== 32'd2) begin
      n_bad++;
      $display("FAIL bp_w3_blocked: got rdy=%b high=%h, want rdy=0 high=2",
               o_ready, o_data_bus[63:32]);
    end
    advance();
    // Release the low branch and keep offering word 3 until it is taken.
    for (int k = 0; k < 8; k++) begin
      logic v;
      v = (mq0.size() + mq1.size() < 3) ? 1'b0 : 1'b1;
      if (k == 0) v = 1'b1;
      drive(1'b0, (k < 3) ? 1'b1 : 1'b0, 32'd3, 2'b11, 1'b1, 2'b11);
      if (k == 0) begin
        n_tot++;
        if (o_ready !== 1'b0 || o_valid !== 2'b01 || o_data_bus[31:0] !== 32'd1) begin
          n_bad++;
          $display("FAIL bp_release0: got rdy=%b vld=%b low=%h, want rdy=0 vld=01 low=1",
                   o_ready, o_valid, o_data_bus[31:0]);
        end
      end
      n_tot++;
      if (o_ready !== m_ready() || o_valid !== m_valid() || o_data_bus !== m_data()) begin
        n_bad++;
        $display("FAIL bp_drain cyc%0d: got rdy=%b vld=%b data=%h, want rdy=%b vld=%b data=%h",
                 k, o_ready, o_valid, o_data_bus, m_ready(), m_valid(), m_data());
      end
      // Only one copy of word 3 is wanted: stop offering once accepted.
      if (i_valid && m_ready()) begin
        advance();
        for (int j = 0; j < 4; j++) begin
          drive(1'b0, 1'b0, '0, 2'b00, 1'b1, 2'b11);
          n_tot++;
          if (o_ready !== m_ready() || o_valid !== m_valid() || o_data_bus !== m_data()) begin
            n_bad++;
            $display("FAIL bp_tail cyc%0d: got rdy=%b vld=%b data=%h, want rdy=%b vld=%b data=%h",
                     j, o_ready, o_valid, o_data_bus, m_ready(), m_valid(), m_data());
          end
          advance();
        end
        break;
      end
      advance();
    end
    n_tot++;
    if (mq0.size() != 0 || mq1.size() != 0 || o_valid !== 2'b00) begin
      n_bad++;
      $display("FAIL bp_empty: got vld=%b, want vld=00 with word 3 delivered", o_valid);
    end
  endtask

  task automatic test_enable_wrap();
    logic [DW-1:0] got[$];
    int idx;
    for (int k = 0; k < 9; k++) begin
      logic e;
      e = !(k >= 2 && k <= 4);
      drive(1'b0, 1'b1, $urandom, 2'($urandom_range(1, 3)), e, 2'b11);
      n_tot++;
      if (o_ready !== m_ready() || o_valid !== m_valid() || o_data_bus !== m_data()
          || (!e && o_ready !== 1'b0)) begin
        n_bad++;
        $display("FAIL enable cyc%0d: got rdy=%b vld=%b data=%h, want rdy=%b vld=%b data=%h",
                 k, o_ready, o_valid, o_data_bus, m_ready(), m_valid(), m_data());
      end
      if (k >= 6) i_valid = 1'b0;
      advance();
    end
    idx = 0;
    for (int k = 0; k < 24; k++) begin
      drive(1'b0, idx < 5, DW'(idx + 1), 2'b01, 1'b1, {2{k[0]}});
      n_tot++;
      if (o_ready !== m_ready() || o_valid !== m_valid() || o_data_bus !== m_data()) begin
        n_bad++;
        $display("FAIL wrap cyc%0d: got rdy=%b vld=%b data=%h, want rdy=%b vld=%b data=%h",
                 k, o_ready, o_valid, o_data_bus, m_ready(), m_valid(), m_data());
      end
      if (o_valid[0] && i_ready[0]) got.push_back(o_data_bus[31:0]);
      if (i_valid && m_ready()) idx++;
      advance();
    end
    n_tot++;
    if (got.size() != 5) begin
      n_bad++;
      $display("FAIL wrap_count: got %0d words, want 5", got.size());
    end else begin
      for (int k = 0; k < 5; k++) begin
        n_tot++;
        if (got[k] !== DW'(k + 1)) begin
          n_bad++;
          $display("FAIL wrap_order[%0d]: got %h want %h", k, got[k], k + 1);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    drive(1'b0, 1'b1, 32'h0000_0A01, 2'b01, 1'b1, 2'b00);
    advance();
    drive(1'b0, 1'b1, 32'h0000_0A02, 2'b01, 1'b1, 2'b00);
    advance();
    drive(1'b1, 1'b0, '0, 2'b01, 1'b1, 2'b00);
    n_tot++;
    if (o_ready !== 1'b0 || o_valid !== 2'b01) begin
      n_bad++;
      $display("FAIL rstmid_full: got rdy=%b vld=%b, want rdy=0 vld=01", o_ready, o_valid);
    end
    advance();
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 1'b0, '0, 2'b01, 1'b1, 2'b11);
      n_tot++;
      if (o_valid !== 2'b00 || o_data_bus !== '0 || o_ready !== 1'b1) begin
        n_bad++;
        $display("FAIL rstmid cyc%0d: got rdy=%b vld=%b data=%h, want rdy=1 vld=00 data=0",
                 k, o_ready, o_valid, o_data_bus);
      end
      advance();
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      drive(($urandom_range(0, 49) == 0), $urandom_range(0, 1), $urandom,
            2'($urandom_range(0, 3)), ($urandom_range(0, 7) != 0), 2'($urandom_range(0, 3)));
      n_tot++;
      if (o_ready !== m_ready() || o_valid !== m_valid() || o_data_bus !== m_data()) begin
        n_bad++;
        $display("FAIL random cyc%0d: got rdy=%b vld=%b data=%h, want rdy=%b vld=%b data=%h",
                 k, o_ready, o_valid, o_data_bus, m_ready(), m_valid(), m_data());
      end
      advance();
    end
  endtask

  initial begin
    rst = 1'b1; i_valid = 1'b0; i_data_bus = '0; i_cmd = 2'b00;
    i_en = 1'b0; i_ready = 2'b00;
    test_reset();
    test_unicast();
    test_multicast_drop();
    test_backpressure();
    test_enable_wrap();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
